control_botones_pwm: RTL

Front-panel setting controller that sits directly upstream of the PWM duty-cycle generator. It synchronizes and debounces four active-high push buttons and turns each press into a saturating step of two registered settings. The settings are the frequency select `Cf` (1..8) and the duty select `Cc` (0..8), which drive the generator's `Cf`/`Cc` inputs directly. Holding a button auto-repeats its step.

---
 rtl/control_botones_pwm.sv | 113 +++++++++++
 1 files changed

// File: rtl/control_botones_pwm.sv
// Front-panel controller: synchronizes and debounces four push buttons and turns
// presses (with hold-to-repeat) into saturating steps of the PWM settings Cf/Cc.
module control_botones_pwm #(
  parameter int unsigned DEB_CYCLES = 500000,
  parameter int unsigned REP_CYCLES = 25000000,
  parameter int unsigned CNT_W      = 26
) (
  input  logic       CLKin,
  input  logic       rst,
  input  logic       btn_f_up,
  input  logic       btn_f_dn,
  input  logic       btn_c_up,
  input  logic       btn_c_dn,
  output logic [3:0] Cf,
  output logic [3:0] Cc,
  output logic       cambio
);

  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEB_CYCLES - 1);
  localparam logic [CNT_W-1:0] REP_LAST = CNT_W'((REP_CYCLES > 0) ? (REP_CYCLES - 1) : 0);
  localparam bit               REP_EN   = (REP_CYCLES > 0);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  localparam logic [3:0] CF_MIN = 4'd1;
  localparam logic [3:0] CF_MAX = 4'd8;
  localparam logic [3:0] CC_MIN = 4'd0;
  localparam logic [3:0] CC_MAX = 4'd8;

  // Button order: 0 f_up, 1 f_dn, 2 c_up, 3 c_dn
  logic [3:0] raw;
  logic [3:0] step;
  logic [3:0] cf_next;
  logic [3:0] cc_next;

  assign raw = {btn_c_dn, btn_c_up, btn_f_dn, btn_f_up};

  for (genvar g = 0; g < 4; g++) begin : g_btn
    logic             s1;
    logic             s2;
    logic             deb;
    logic             deb_q;
    logic             rep_q;
    logic [CNT_W-1:0] dcnt;
    logic [CNT_W-1:0] rcnt;

    always_ff @(posedge CLKin) begin
      if (rst) begin
        s1    <= 1'b0;
        s2    <= 1'b0;
        deb   <= 1'b0;
        deb_q <= 1'b0;
        dcnt  <= '0;
      end else begin
        s1    <= raw[g];
        s2    <= s1;
        deb_q <= deb;
        if (s2 == deb) begin
          dcnt <= '0;
        end else if (dcnt == DEB_LAST) begin
          deb  <= ~deb;
          dcnt <= '0;
        end else begin
          dcnt <= dcnt + CNT_ONE;
        end
      end
    end

    // Repeat request is registered so that it lands REP_CYCLES after the
    // initial step; it is gated with deb so a release never yields a step.
    always_ff @(posedge CLKin) begin
      if (rst || !REP_EN || !deb) begin
        rcnt  <= '0;
        rep_q <= 1'b0;
      end else if (rcnt == REP_LAST) begin
        rcnt  <= '0;
        rep_q <= 1'b1;
      end else begin
        rcnt  <= rcnt + CNT_ONE;
        rep_q <= 1'b0;
      end
    end

    assign step[g] = deb & (~deb_q | rep_q);
  end

  always_comb begin
    cf_next = Cf;
    cc_next = Cc;
    if (step[0] && !step[1]) begin
      if (Cf < CF_MAX) cf_next = Cf + 4'd1;
    end else if (step[1] && !step[0]) begin
      if (Cf > CF_MIN) cf_next = Cf - 4'd1;
    end
    if (step[2] && !step[3]) begin
      if (Cc < CC_MAX) cc_next = Cc + 4'd1;
    end else if (step[3] && !step[2]) begin
      if (Cc > CC_MIN) cc_next = Cc - 4'd1;
    end
  end

  always_ff @(posedge CLKin) begin
    if (rst) begin
      Cf     <= CF_MIN;
      Cc     <= CC_MIN;
      cambio <= 1'b0;
    end else begin
      Cf     <= cf_next;
      Cc     <= cc_next;
      cambio <= (cf_next != Cf) || (cc_next != Cc);
    end
  end

endmodule
